// File: rtl/route_if.sv
// route_if: command, station-ID and motion/buzzer signals of the route controller
// master drives cmd/cmd_rdy, ID/ID_vld, OK2Move; slave (route_cntrl) drives the rest.
interface route_if #(
    parameter int ID_W  = 6,
    parameter int DEPTH = 4
);
    logic [ID_W+1:0]              cmd;
    logic                         cmd_rdy;
    logic                         clr_cmd_rdy;
    logic [ID_W-1:0]              ID;
    logic                         ID_vld;
    logic                         clr_ID_vld;
    logic                         OK2Move;
    logic                         in_transit;
    logic                         go;
    logic                         buzz;
    logic                         buzz_n;
    logic [ID_W-1:0]              cur_dest;
    logic [$clog2(DEPTH+1)-1:0]   q_cnt;
    logic                         arrived;
    logic                         err;
    modport master (
        output cmd, cmd_rdy, ID, ID_vld, OK2Move,
        input  clr_cmd_rdy, clr_ID_vld, in_transit, go, buzz, buzz_n, cur_dest, q_cnt, arrived, err
    );
    modport slave (
        input  cmd, cmd_rdy, ID, ID_vld, OK2Move,
        output clr_cmd_rdy, clr_ID_vld, in_transit, go, buzz, buzz_n, cur_dest, q_cnt, arrived, err
    );
endinterface

// File: rtl/route_cntrl.sv
// route_cntrl: multi-stop route controller with destination FIFO and obstruction buzzer
// Ports: clk; rst_n (async, active-low); r (route_if.slave): cmd/cmd_rdy/clr_cmd_rdy command
// handshake, ID/ID_vld/clr_ID_vld station handshake, OK2Move, in_transit, go, buzz/buzz_n,
// cur_dest (FIFO head), q_cnt, arrived and err pulses.
module route_cntrl #(
    parameter int ID_W        = 6,
    parameter int DEPTH       = 4,
    parameter int BUZZ_PERIOD = 12500,
    parameter int BUZZ_HIGH   = 6250
) (
    input logic    clk,
    input logic    rst_n,
    route_if.slave r
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);
    localparam int BW = $clog2(BUZZ_PERIOD);
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [PW-1:0] LAST   = PW'(DEPTH-1);
    localparam logic [BW-1:0] B_LAST = BW'(BUZZ_PERIOD-1);
    localparam logic [BW-1:0] B_ON   = BW'(BUZZ_PERIOD-BUZZ_HIGH);
    typedef enum logic {IDLE, MOVE} state_t;
    state_t          state;
    logic [ID_W-1:0] mem [DEPTH];
    logic [PW-1:0]   rd, wr;
    logic [CW-1:0]   cnt;
    logic [BW-1:0]   bcnt;
    logic [1:0]      op;
    logic [ID_W-1:0] cid;
    logic            full, empty, hit, push, pop, en;
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == LAST ? '0 : p + PW'(1);
    endfunction
    assign op    = r.cmd[ID_W+:2];
    assign cid   = r.cmd[ID_W-1:0];
    assign full  = cnt == FULL;
    assign empty = cnt == '0;
    assign r.clr_cmd_rdy = r.cmd_rdy;
    // a pending command always wins; the ID is left pending for a later cycle
    assign r.clr_ID_vld  = ~r.cmd_rdy & r.ID_vld;
    assign r.cur_dest    = empty ? '0 : mem[rd];
    assign hit  = r.clr_ID_vld & (state == MOVE) & ~empty & (r.ID == r.cur_dest);
    assign push = r.cmd_rdy & (op == 2'b01 | (op == 2'b10 & ~full));
    assign pop  = r.cmd_rdy ? (op == 2'b11 & ~empty) : hit;
    assign r.in_transit = state == MOVE;
    assign r.go         = r.in_transit & r.OK2Move;
    assign r.q_cnt      = cnt;
    assign en           = r.in_transit & ~r.OK2Move;
    assign r.buzz       = en & (bcnt >= B_ON);
    assign r.buzz_n     = en & ~r.buzz;
    // GO always lands in slot 0 because it also resets the pointers
    always_ff @(posedge clk)
        if (push) mem[op == 2'b01 ? '0 : wr] <= cid;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= IDLE;
            rd        <= '0;
            wr        <= '0;
            cnt       <= '0;
            bcnt      <= '0;
            r.arrived <= 1'b0;
            r.err     <= 1'b0;
        end else begin
            r.arrived <= hit;
            r.err     <= r.cmd_rdy & ((op == 2'b10 & full) | (op == 2'b11 & empty));
            bcnt      <= (~en | bcnt == B_LAST) ? '0 : bcnt + BW'(1);
            if (r.cmd_rdy && !op[1]) begin
                rd    <= '0;
                wr    <= op[0] ? nxt('0) : '0;
                cnt   <= CW'(op[0]);
                state <= op[0] ? MOVE : IDLE;
            end else begin
                if (push) begin
                    wr    <= nxt(wr);
                    cnt   <= cnt + CW'(1);
                    state <= MOVE;
                end
                if (pop) begin
                    rd  <= nxt(rd);
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= IDLE;
                end
            end
        end
endmodule

// File: tb/tb_route_cntrl.sv
// tb_route_cntrl: vector table, buzzer/reset sequences and randomized run against a queue model
module tb_route_cntrl;
    localparam int ID_W = 6, DEPTH = 4, P = 20, H = 7;
    logic clk = 1'b0, rst_n = 1'b0;
    int total = 0, passed = 0;
    always #5 clk = ~clk;
    route_if #(.ID_W(ID_W), .DEPTH(DEPTH)) r();
    route_cntrl #(.ID_W(ID_W), .DEPTH(DEPTH), .BUZZ_PERIOD(P), .BUZZ_HIGH(H)) dut (
        .clk(clk), .rst_n(rst_n), .r(r.slave)
    );
    typedef struct {
        bit cr; int op; int cid; bit iv; int id;
        bit it; int q; int cd; bit arr; bit err;
    } vec_t;
    vec_t tv[$];
    task automatic chk(input string n, input logic [31:0] a, input int e);
        total++;
        if (a === 32'(e)) passed++;
        else $display("FAIL %s act=%0d exp=%0d", n, a, e);
    endtask
    task automatic add(input bit cr, input int op, cid, input bit iv, input int id,
                       input bit it, input int q, cd, input bit arr, err);
        vec_t v;
        v.cr = cr; v.op = op; v.cid = cid; v.iv = iv; v.id = id;
        v.it = it; v.q = q; v.cd = cd; v.arr = arr; v.err = err;
        tv.push_back(v);
    endtask
    task automatic c(input int op, cid, input bit it, input int q, cd, input bit err = 0);
        add(1, op, cid, 0, 0, it, q, cd, 0, err);
    endtask
    task automatic i(input int id, input bit it, input int q, cd, input bit arr);
        add(0, 0, 0, 1, id, it, q, cd, arr, 0);
    endtask
    task automatic drive(input bit cr, input int op, cid, input bit iv, input int id, input bit ok);
        @(negedge clk);
        r.cmd_rdy = cr;
        r.cmd     = (ID_W+2)'((op << ID_W) | cid);
        r.ID_vld  = iv;
        r.ID      = ID_W'(id);
        r.OK2Move = ok;
    endtask
    initial begin
        bit prev_it, eb, cr, ok, ipend, mv, earr, eerr, ecivl;
        int highs, op, cid, iid, ecyc, head;
        int mq[$];
        r.cmd_rdy = 0; r.cmd = '0; r.ID_vld = 0; r.ID = '0; r.OK2Move = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_transit", r.in_transit, 0);
        chk("rst_q_cnt", r.q_cnt, 0);
        chk("rst_cur_dest", r.cur_dest, 0);
        chk("rst_go", r.go, 0);
        chk("rst_buzz", r.buzz, 0);
        chk("rst_buzz_n", r.buzz_n, 0);
        chk("rst_arrived", r.arrived, 0);
        chk("rst_err", r.err, 0);
        @(negedge clk) rst_n = 1;
        c(1, 5, 1, 1, 5);     i(5, 0, 0, 0, 1);    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        c(1, 3, 1, 1, 3);     c(2, 7, 1, 2, 3);    c(2, 9, 1, 3, 3);
        i(7, 1, 3, 3, 0);     i(3, 1, 2, 7, 1);    i(7, 1, 1, 9, 1);    i(9, 0, 0, 0, 1);
        c(2, 1, 1, 1, 1);     c(2, 2, 1, 2, 1);    c(2, 3, 1, 3, 1);    c(2, 4, 1, 4, 1);
        c(2, 5, 1, 4, 1, 1);
        c(3, 0, 1, 3, 2);     c(3, 0, 1, 2, 3);    c(3, 0, 1, 1, 4);    c(3, 0, 0, 0, 0);
        c(3, 0, 0, 0, 0, 1);
        i(4, 0, 0, 0, 0);
        c(1, 8, 1, 1, 8);     add(1, 0, 0, 1, 8, 0, 0, 0, 0, 0);    i(8, 0, 0, 0, 0);
        c(1, 1, 1, 1, 1);     c(2, 2, 1, 2, 1);    c(3, 0, 1, 1, 2);
        c(2, 3, 1, 2, 2);     c(2, 4, 1, 3, 2);    c(2, 5, 1, 4, 2);    c(2, 6, 1, 4, 2, 1);
        i(2, 1, 3, 3, 1);     i(3, 1, 2, 4, 1);    i(4, 1, 1, 5, 1);    i(5, 0, 0, 0, 1);
        c(2, 9, 1, 1, 9);     c(2, 10, 1, 2, 9);   c(1, 12, 1, 1, 12);  c(0, 0, 0, 0, 0);
        prev_it = 0;
        foreach (tv[k]) begin
            drive(tv[k].cr, tv[k].op, tv[k].cid, tv[k].iv, tv[k].id, 1);
            #1;
            chk($sformatf("v%0d_clr_cmd", k), r.clr_cmd_rdy, tv[k].cr);
            chk($sformatf("v%0d_clr_id", k), r.clr_ID_vld, !tv[k].cr && tv[k].iv);
            chk($sformatf("v%0d_go", k), r.go, prev_it);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_in_transit", k), r.in_transit, tv[k].it);
            chk($sformatf("v%0d_q_cnt", k), r.q_cnt, tv[k].q);
            chk($sformatf("v%0d_cur_dest", k), r.cur_dest, tv[k].cd);
            chk($sformatf("v%0d_arrived", k), r.arrived, tv[k].arr);
            chk($sformatf("v%0d_err", k), r.err, tv[k].err);
            prev_it = tv[k].it;
        end
        drive(1, 1, 20, 0, 0, 1);
        highs = 0;
        for (int k = 0; k < 2 * P; k++) begin
            drive(0, 0, 0, 0, 0, 0);
            #1;
            eb = (k % P) >= P - H;
            highs += int'(r.buzz);
            chk($sformatf("bz%0d_go", k), r.go, 0);
            chk($sformatf("bz%0d_buzz", k), r.buzz, eb);
            chk($sformatf("bz%0d_buzz_n", k), r.buzz_n, !eb);
            if (k % P == P - 1) begin
                chk("bz_high_cycles", highs, H);
                highs = 0;
            end
        end
        drive(0, 0, 0, 0, 0, 1);
        #1;
        chk("bz_clear_buzz", r.buzz, 0);
        chk("bz_clear_buzz_n", r.buzz_n, 0);
        chk("bz_clear_go", r.go, 1);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("bz_restart_buzz", r.buzz, 0);
        chk("bz_restart_buzz_n", r.buzz_n, 1);
        drive(1, 1, 1, 0, 0, 1);
        drive(1, 2, 2, 0, 0, 1);
        drive(1, 2, 3, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        #1;
        chk("rm_q_cnt", r.q_cnt, 3);
        chk("rm_go", r.go, 1);
        #2 rst_n = 0;
        #1;
        chk("rm_in_transit", r.in_transit, 0);
        chk("rm_go_low", r.go, 0);
        chk("rm_q_cnt_low", r.q_cnt, 0);
        chk("rm_cur_dest", r.cur_dest, 0);
        chk("rm_buzz", r.buzz | r.buzz_n, 0);
        chk("rm_pulses", r.arrived | r.err, 0);
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;
        chk("rm_q_cnt_after", r.q_cnt, 0);
        chk("rm_in_transit_after", r.in_transit, 0);
        mv = 0; ecyc = 0; ipend = 0; iid = 0;
        for (int k = 0; k < 3000; k++) begin
            cr  = $urandom_range(0, 2) == 0;
            op  = $urandom_range(0, 9);
            op  = op == 0 ? 0 : op == 1 ? 1 : op < 7 ? 2 : 3;
            cid = $urandom_range(0, 7);
            if (!ipend && $urandom_range(0, 1) == 1) begin
                ipend = 1;
                iid = (mq.size() > 0 && $urandom_range(0, 1) == 1) ? mq[0] : int'($urandom_range(0, 7));
            end
            ok = $urandom_range(0, 5) != 0;
            drive(cr, op, cid, ipend, iid, ok);
            #1;
            head  = mq.size() > 0 ? mq[0] : 0;
            ecivl = !cr && ipend;
            eb    = mv && !ok && (ecyc % P) >= P - H;
            chk("rnd_clr_cmd", r.clr_cmd_rdy, cr);
            chk("rnd_clr_id", r.clr_ID_vld, ecivl);
            chk("rnd_in_transit", r.in_transit, mv);
            chk("rnd_go", r.go, mv && ok);
            chk("rnd_q_cnt", r.q_cnt, mq.size());
            chk("rnd_cur_dest", r.cur_dest, head);
            chk("rnd_buzz", r.buzz, eb);
            chk("rnd_buzz_n", r.buzz_n, mv && !ok && !eb);
            ecyc = (mv && !ok) ? ecyc + 1 : 0;
            earr = 0; eerr = 0;
            if (cr) begin
                if (op == 0) begin mq.delete(); mv = 0; end
                else if (op == 1) begin mq = {cid}; mv = 1; end
                else if (op == 2) begin
                    if (mq.size() == DEPTH) eerr = 1;
                    else begin mq.push_back(cid); mv = 1; end
                end else begin
                    if (mq.size() == 0) eerr = 1;
                    else begin void'(mq.pop_front()); mv = mq.size() > 0; end
                end
            end else if (ipend && mv && mq.size() > 0 && iid == head) begin
                void'(mq.pop_front());
                earr = 1;
                mv = mq.size() > 0;
            end
            if (ecivl) ipend = 0;
            @(posedge clk);
            #1;
            chk("rnd_arrived", r.arrived, earr);
            chk("rnd_err", r.err, eerr);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
